// File: rtl/bpu_gshare_if.sv
// F1 lookup / EXE training / statistics bundle for the gshare predictor.
// master = fetch+execute side, slave = predictor.
interface bpu_gshare_if #(
  parameter int HIST_BITS = 8
);
  logic                 f1_valid;
  logic [31:0]          f1_pc;
  logic                 f1_taken;
  logic [31:0]          f1_pre_pc;
  logic [HIST_BITS-1:0] f1_ghr;

  logic                 exe_valid;
  logic [31:0]          exe_pc;
  logic                 exe_is_branch;
  logic                 exe_is_jump;
  logic                 exe_taken;
  logic [31:0]          exe_dest_pc;
  logic [HIST_BITS-1:0] exe_ghr;
  logic                 exe_mispredict;

  logic [31:0]          stat_branches;
  logic [31:0]          stat_mispred;

  modport master (
    output f1_valid, f1_pc,
    output exe_valid, exe_pc, exe_is_branch, exe_is_jump,
    output exe_taken, exe_dest_pc, exe_ghr, exe_mispredict,
    input  f1_taken, f1_pre_pc, f1_ghr,
    input  stat_branches, stat_mispred
  );

  modport slave (
    input  f1_valid, f1_pc,
    input  exe_valid, exe_pc, exe_is_branch, exe_is_jump,
    input  exe_taken, exe_dest_pc, exe_ghr, exe_mispredict,
    output f1_taken, f1_pre_pc, f1_ghr,
    output stat_branches, stat_mispred
  );
endinterface

// File: rtl/bpu_gshare.sv
// Gshare direction predictor + direct-mapped BTB for the F1 stage.
// Optional resolve/mispredict counters: define BPU_STATS_EN.
module bpu_gshare #(
  parameter int BTB_ENTRIES  = 64,
  parameter int PHT_ENTRIES  = 1024,
  parameter int HIST_BITS    = 8,
  parameter int COUNTER_BITS = 2
) (
  input logic        clk,
  input logic        resetn,
  bpu_gshare_if.slave bus
);
  localparam int BI = $clog2(BTB_ENTRIES);
  localparam int PI = $clog2(PHT_ENTRIES);
  localparam int TW = 30 - BI;
  localparam int CB = COUNTER_BITS;
  localparam logic [CB-1:0] CNT_INIT = CB'((1 << (CB - 1)) - 1);
  localparam logic [CB-1:0] CNT_MAX  = '1;

  logic [BTB_ENTRIES-1:0] btb_v;
  logic [BTB_ENTRIES-1:0] btb_j;
  logic [TW-1:0]          btb_tag [BTB_ENTRIES];
  logic [31:0]            btb_tgt [BTB_ENTRIES];
  logic [CB-1:0]          pht [PHT_ENTRIES];
  logic [HIST_BITS-1:0]   ghr;
  logic [HIST_BITS-1:0]   ghr_d;

  logic [BI-1:0] f_bi;
  logic [TW-1:0] f_tag;
  logic [PI-1:0] f_pi;
  logic          f_hit;
  logic          f_dir;

  assign f_bi  = bus.f1_pc[2+:BI];
  assign f_tag = bus.f1_pc[31:2+BI];
  assign f_pi  = bus.f1_pc[2+:PI] ^ PI'(ghr);
  assign f_hit = btb_v[f_bi] & (btb_tag[f_bi] == f_tag);
  assign f_dir = pht[f_pi][CB-1];

  assign bus.f1_taken  = bus.f1_valid & f_hit
                       & (btb_j[f_bi] | f_dir);
  assign bus.f1_pre_pc = bus.f1_taken ? btb_tgt[f_bi] : '0;
  assign bus.f1_ghr    = ghr;

  // Both type flags set is illegal; it resolves as a jump.
  logic          e_jmp;
  logic          e_br;
  logic          e_mis;
  logic          e_alloc;
  logic [BI-1:0] e_bi;
  logic [TW-1:0] e_tag;
  logic [PI-1:0] e_pi;
  logic [CB-1:0] e_cnt;
  logic [CB-1:0] e_cnt_d;

  assign e_jmp   = bus.exe_valid & bus.exe_is_jump;
  assign e_br    = bus.exe_valid & bus.exe_is_branch
                 & ~bus.exe_is_jump;
  assign e_mis   = bus.exe_valid & bus.exe_mispredict;
  assign e_alloc = e_jmp | (e_br & bus.exe_taken);
  assign e_bi    = bus.exe_pc[2+:BI];
  assign e_tag   = bus.exe_pc[31:2+BI];
  assign e_pi    = bus.exe_pc[2+:PI] ^ PI'(bus.exe_ghr);
  assign e_cnt   = pht[e_pi];

  always_comb begin
    e_cnt_d = e_cnt;
    if (bus.exe_taken && e_cnt != CNT_MAX)
      e_cnt_d = e_cnt + CB'(1);
    else if (!bus.exe_taken && e_cnt != '0)
      e_cnt_d = e_cnt - CB'(1);
  end

  // Repair beats speculation; a flushed fetch must not shift in.
  always_comb begin
    ghr_d = ghr;
    if (e_br & e_mis)
      ghr_d = {bus.exe_ghr[HIST_BITS-2:0], bus.exe_taken};
    else if (e_jmp & e_mis)
      ghr_d = bus.exe_ghr;
    else if (bus.f1_valid & f_hit & ~btb_j[f_bi])
      ghr_d = {ghr[HIST_BITS-2:0], f_dir};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ghr   <= '0;
      btb_v <= '0;
      btb_j <= '0;
      for (int i = 0; i < PHT_ENTRIES; i++)
        pht[i] <= CNT_INIT;
    end else begin
      ghr <= ghr_d;
      if (e_br)
        pht[e_pi] <= e_cnt_d;
      if (e_alloc) begin
        btb_v[e_bi] <= 1'b1;
        btb_j[e_bi] <= e_jmp;
      end
    end
  end

  // Tag/target are qualified by btb_v, so they need no reset.
  always_ff @(posedge clk) begin
    if (e_alloc) begin
      btb_tag[e_bi] <= e_tag;
      btb_tgt[e_bi] <= bus.exe_dest_pc;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] sb_q;
  logic [31:0] sm_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb_q <= '0;
      sm_q <= '0;
    end else begin
      if ((e_br | e_jmp) && sb_q != '1)
        sb_q <= sb_q + 32'd1;
      if (e_mis && sm_q != '1)
        sm_q <= sm_q + 32'd1;
    end
  end

  assign bus.stat_branches = sb_q;
  assign bus.stat_mispred  = sm_q;
`else
  assign bus.stat_branches = '0;
  assign bus.stat_mispred  = '0;
`endif

  logic unused_lsb;
  assign unused_lsb = ^{bus.f1_pc[1:0], bus.exe_pc[1:0]};

endmodule

// File: tb/tb_bpu_gshare.sv
// Bench for bpu_gshare: directed table, random run against a model,
// async reset mid-run, optional statistics counters.
`timescale 1ns/1ps
module tb_bpu_gshare;
  localparam int BE = 64;
  localparam int PE = 1024;
  localparam int HB = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  bpu_gshare_if #(.HIST_BITS(HB)) bus ();

  bpu_gshare #(
    .BTB_ENTRIES (BE),
    .PHT_ENTRIES (PE),
    .HIST_BITS   (HB),
    .COUNTER_BITS(2)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    logic        fv;
    logic [31:0] fpc;
    logic        ev;
    logic [31:0] epc;
    logic        br;
    logic        jp;
    logic        tk;
    logic [31:0] dst;
    logic [7:0]  eg;
    logic        mis;
    logic        x_tk;
    logic [31:0] x_pc;
    logic [7:0]  x_ghr;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: plain arrays indexed by arithmetic on the PC
  bit          m_v   [BE];
  bit          m_j   [BE];
  int unsigned m_tag [BE];
  int unsigned m_tgt [BE];
  int          m_pht [PE];
  int unsigned m_ghr;
  longint unsigned m_sb;
  longint unsigned m_sm;

  function automatic void m_reset();
    for (int i = 0; i < BE; i++) m_v[i] = 0;
    for (int i = 0; i < PE; i++) m_pht[i] = 1;
    m_ghr = 0;
    m_sb  = 0;
    m_sm  = 0;
  endfunction

  function automatic bit m_hit(input int unsigned pc);
    int unsigned bi = (pc / 4) % BE;
    return m_v[bi] && m_tag[bi] == pc / (4 * BE);
  endfunction

  function automatic bit m_dir(input int unsigned pc);
    return m_pht[((pc / 4) % PE) ^ m_ghr] >= 2;
  endfunction

  function automatic void m_predict(input vec_t v, output bit tk,
                                    output logic [31:0] tgt);
    int unsigned bi = (v.fpc / 4) % BE;
    tk  = v.fv && m_hit(v.fpc) && (m_j[bi] || m_dir(v.fpc));
    tgt = tk ? m_tgt[bi] : 0;
  endfunction

  function automatic void m_update(input vec_t v);
    int unsigned bi  = (v.fpc / 4) % BE;
    bit          jmp = v.ev && v.jp;
    bit          br  = v.ev && v.br && !v.jp;
    int unsigned nxt = m_ghr;
    int unsigned ei;
    int unsigned pi;
    if (br && v.mis)
      nxt = (v.eg * 2 + v.tk) % 256;
    else if (jmp && v.mis)
      nxt = v.eg;
    else if (v.fv && m_hit(v.fpc) && !m_j[bi])
      nxt = (m_ghr * 2 + m_dir(v.fpc)) % 256;
    if (br) begin
      pi = ((v.epc / 4) % PE) ^ v.eg;
      if (v.tk) m_pht[pi] = (m_pht[pi] < 3) ? m_pht[pi] + 1 : 3;
      else      m_pht[pi] = (m_pht[pi] > 0) ? m_pht[pi] - 1 : 0;
    end
    if (jmp || (br && v.tk)) begin
      ei = (v.epc / 4) % BE;
      m_v[ei]   = 1;
      m_j[ei]   = jmp;
      m_tag[ei] = v.epc / (4 * BE);
      m_tgt[ei] = v.dst;
    end
    if ((br || jmp) && m_sb < 64'hFFFF_FFFF) m_sb++;
    if (v.ev && v.mis && m_sm < 64'hFFFF_FFFF) m_sm++;
    m_ghr = nxt;
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic vec_t mk(
    input logic fv, input logic [31:0] fpc,
    input logic ev, input logic [31:0] epc,
    input logic br, input logic jp, input logic tk,
    input logic [31:0] dst, input logic [7:0] eg, input logic mis,
    input logic x_tk, input logic [31:0] x_pc, input logic [7:0] x_ghr);
    vec_t v;
    v.fv = fv;  v.fpc = fpc; v.ev = ev; v.epc = epc;
    v.br = br;  v.jp = jp;   v.tk = tk; v.dst = dst;
    v.eg = eg;  v.mis = mis;
    v.x_tk = x_tk; v.x_pc = x_pc; v.x_ghr = x_ghr;
    return v;
  endfunction

  // drive at negedge, check combinational lookup 1ns later
  task automatic step(input vec_t v, input bit use_tbl, input string n);
    bit          etk;
    logic [31:0] epre;
    logic [7:0]  eg;
    @(negedge clk);
    bus.f1_valid       = v.fv;
    bus.f1_pc          = v.fpc;
    bus.exe_valid      = v.ev;
    bus.exe_pc         = v.epc;
    bus.exe_is_branch  = v.br;
    bus.exe_is_jump    = v.jp;
    bus.exe_taken      = v.tk;
    bus.exe_dest_pc    = v.dst;
    bus.exe_ghr        = v.eg;
    bus.exe_mispredict = v.mis;
    #1;
    m_predict(v, etk, epre);
    eg = 8'(m_ghr);
    if (use_tbl) begin
      etk  = v.x_tk;
      epre = v.x_pc;
      eg   = v.x_ghr;
    end
    chk({n, " f1_taken"},  32'(bus.f1_taken), 32'(etk));
    chk({n, " f1_pre_pc"}, bus.f1_pre_pc, epre);
    chk({n, " f1_ghr"},    32'(bus.f1_ghr), 32'(eg));
    m_update(v);
  endtask

  vec_t tbl[16];
  vec_t rv;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.f1_valid = 1'b1;  bus.f1_pc = 32'h1000;
    bus.exe_valid = 1'b0; bus.exe_pc = '0;
    bus.exe_is_branch = 1'b0; bus.exe_is_jump = 1'b0;
    bus.exe_taken = 1'b0; bus.exe_dest_pc = '0;
    bus.exe_ghr = '0; bus.exe_mispredict = 1'b0;
    m_reset();

    tbl[0]  = mk(1,32'h1000,0,0,0,0,0,0,0,0,            0,0,0);
    tbl[1]  = mk(1,32'h1000,1,32'h1000,0,1,0,32'h2000,0,0, 0,0,0);
    tbl[2]  = mk(1,32'h1000,0,0,0,0,0,0,0,0,            1,32'h2000,0);
    tbl[3]  = mk(1,32'h1000,0,0,0,0,0,0,0,0,            1,32'h2000,0);
    tbl[4]  = mk(0,0,1,32'h1100,1,0,1,32'h1200,0,0,    0,0,0);
    tbl[5]  = mk(1,32'h1100,1,32'h1100,1,0,1,32'h1200,0,0,
                 1,32'h1200,0);
    tbl[6]  = mk(0,0,0,0,0,0,0,0,0,0,                  0,0,8'h01);
    tbl[7]  = mk(1,32'h1100,1,32'h3000,1,0,0,32'h3100,8'h5A,1,
                 0,0,8'h01);
    tbl[8]  = mk(0,0,0,0,0,0,0,0,0,0,                  0,0,8'hB4);
    tbl[9]  = mk(1,32'h1000,1,32'h1100,0,1,0,32'h4000,0,0,
                 0,0,8'hB4);
    tbl[10] = mk(1,32'h1000,0,0,0,0,0,0,0,0,           0,0,8'hB4);
    tbl[11] = mk(1,32'h1100,0,0,0,0,0,0,0,0,           1,32'h4000,8'hB4);
    tbl[12] = mk(1,32'h1100,1,32'h1000,1,0,0,32'h7000,0,0,
                 1,32'h4000,8'hB4);
    tbl[13] = mk(1,32'h1100,0,0,0,0,0,0,0,0,           1,32'h4000,8'hB4);
    tbl[14] = mk(0,0,1,32'h2000,1,1,0,32'h5000,8'h33,1,
                 0,0,8'hB4);
    tbl[15] = mk(1,32'h2000,0,0,0,0,0,0,0,0,           1,32'h5000,8'h33);

    repeat (2) @(negedge clk);
    #1;
    chk("reset f1_taken",  32'(bus.f1_taken), 0);
    chk("reset f1_pre_pc", bus.f1_pre_pc, 0);
    chk("reset f1_ghr",    32'(bus.f1_ghr), 0);
    chk("reset stat_branches", bus.stat_branches, 0);
    chk("reset stat_mispred",  bus.stat_mispred, 0);
    resetn = 1'b1;

    for (int i = 0; i < 16; i++)
      step(tbl[i], 1'b1, $sformatf("vec%0d", i));

    for (int i = 0; i < 400; i++) begin
      rv.fv  = ($urandom_range(0, 3) != 0);
      rv.fpc = 32'h1000 + 4 * $urandom_range(0, 15)
             + 256 * $urandom_range(0, 3);
      rv.ev  = $urandom_range(0, 1);
      rv.epc = 32'h1000 + 4 * $urandom_range(0, 15)
             + 256 * $urandom_range(0, 3);
      rv.br  = ($urandom_range(0, 3) != 0);
      rv.jp  = ($urandom_range(0, 4) == 0);
      rv.tk  = $urandom_range(0, 1);
      rv.dst = {$urandom_range(0, 16'hFFFF), 14'h0, 2'b00};
      rv.eg  = ($urandom_range(0, 1) != 0) ? 8'(m_ghr)
                                          : 8'($urandom_range(0, 255));
      rv.mis = ($urandom_range(0, 3) == 0);
      step(rv, 1'b0, $sformatf("rnd%0d", i));
    end

`ifdef BPU_STATS_EN
    @(negedge clk);
    #1;
    chk("stat_branches", bus.stat_branches, 32'(m_sb));
    chk("stat_mispred",  bus.stat_mispred,  32'(m_sm));
    dut.sb_q = 32'hFFFF_FFFE;
    m_sb = 64'hFFFF_FFFE;
    for (int i = 0; i < 3; i++)
      step(mk(0,0,1,32'h1800,1,0,0,0,0,0,0,0,0), 1'b0, "sat");
    @(negedge clk);
    #1;
    chk("stat_branches sat", bus.stat_branches, 32'hFFFF_FFFF);
    chk("stat_branches model", bus.stat_branches, 32'(m_sb));
`else
    @(negedge clk);
    #1;
    chk("stat_branches off", bus.stat_branches, 0);
    chk("stat_mispred off",  bus.stat_mispred, 0);
`endif

    step(mk(0,0,1,32'h1000,0,1,0,32'h2000,0,0,0,0,0), 1'b0, "pre_rst_a");
    step(mk(1,32'h1000,0,0,0,0,0,0,0,0,1,32'h2000,8'(m_ghr)),
         1'b1, "pre_rst_b");
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    m_reset();
    chk("async rst f1_taken",  32'(bus.f1_taken), 0);
    chk("async rst f1_pre_pc", bus.f1_pre_pc, 0);
    chk("async rst f1_ghr",    32'(bus.f1_ghr), 0);
    chk("async rst stat_branches", bus.stat_branches, 0);
    @(negedge clk);
    resetn = 1'b1;
    step(mk(1,32'h1000,0,0,0,0,0,0,0,0,0,0,0), 1'b1, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
